cr_osf_ob_gate: RTL

// - Output gate for the OSF data FIFO. Pops the FIFO into a 2-entry output skid buffer and drives the outbound stream.
// - Applies the debug controls set by the OSF regfile: normal run, halt, single-step, and stop-at-end-of-block.
// - Sources the outbound byte/frame counter strobes and the data-FIFO debug status back to the regfile.

---
 rtl/cr_osf_ob_gate_pkg.sv | 28 ++
 rtl/cr_osf_ob_skid.sv | 63 ++++++
 rtl/cr_osf_ob_gate.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cr_osf_ob_gate_pkg.sv
// Shared types for the OSF outbound gate: debug modes,
// gate FSM states and the packed debug status word.
package cr_osf_ob_gate_pkg;

  localparam int OB_BV_W   = 4;
  localparam int OB_STAT_W = 24;

  typedef enum logic [1:0] {
    DBG_RUN      = 2'd0,
    DBG_HALT     = 2'd1,
    DBG_SSTEP    = 2'd2,
    DBG_STOP_EOB = 2'd3
  } osf_ob_dbg_mode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } osf_ob_gate_state_e;

  typedef struct packed {
    osf_ob_gate_state_e state;
    logic [3:0]         ss_credit;
    logic [1:0]         occ;
    logic [15:0]        pop_cnt;
  } ob_gate_dbg_stat_t;

endpackage

// File: rtl/cr_osf_ob_skid.sv
// Two-entry FIFO-ordered skid buffer; entry 0 is the
// head and always drives the outbound word.
module cr_osf_ob_skid #(
  parameter int W = 69
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         vld_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = din_i;
        else               e1_d = din_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // full and swapping: shift head out, new word to tail
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = din_i;
        end else begin
          e0_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign dout_o = e0_q;
  assign vld_o  = (occ_q != 2'd0);
  assign occ_o  = occ_q;

endmodule

// File: rtl/cr_osf_ob_gate.sv
// OSF data-FIFO output gate: credit-limited pops into a
// skid buffer, debug run/halt/step control, count strobes.
module cr_osf_ob_gate
  import cr_osf_ob_gate_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SSC_W  = 4,
  parameter int POPC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_eob,
  input  logic [3:0]        fifo_bytes_vld,
  output logic              ob_valid,
  input  logic              ob_ready,
  output logic [DATA_W-1:0] ob_data,
  output logic              ob_eob,
  output logic [3:0]        ob_bytes_vld,
  input  logic [1:0]        dbg_mode,
  input  logic              single_step_rd,
  output logic              ob_bytes_cnt_stb,
  output logic [3:0]        ob_bytes_cnt_amt,
  output logic              ob_frame_cnt_stb,
  output logic [23:0]       dbg_stat
);

  localparam int EW = DATA_W + 5;
  localparam logic [SSC_W:0] CRED_MAX =
    {1'b0, {SSC_W{1'b1}}};

  osf_ob_gate_state_e state_q, state_d;
  logic               stop_q, stop_d;
  logic [SSC_W-1:0]   cred_q, cred_d;
  logic [POPC_W-1:0]  popc_q, popc_d;
  logic               inflight_q;
  logic               stb_q, frm_q;
  logic [3:0]         amt_q;

  logic          deq;
  logic          pop_en;
  logic          rd;
  logic          cap_eob;
  logic [1:0]    occ;
  logic [2:0]    fill;
  logic [EW-1:0] head;
  logic [SSC_W:0] csum;

  cr_osf_ob_skid #(.W(EW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .din_i  ({fifo_eob, fifo_bytes_vld, fifo_rdata}),
    .pop_i  (deq),
    .dout_o (head),
    .vld_o  (ob_valid),
    .occ_o  (occ)
  );

  assign ob_eob       = head[EW-1];
  assign ob_bytes_vld = head[EW-2:DATA_W];
  assign ob_data      = head[DATA_W-1:0];

  assign deq  = ob_valid & ob_ready;
  assign fill = {1'b0, occ} + {2'b0, inflight_q};

  always_comb begin
    pop_en = 1'b0;
    unique case (state_q)
      ST_RUN:  pop_en = 1'b1;
      ST_STEP: pop_en = (cred_q != '0);
      default: pop_en = 1'b0;
    endcase
  end

  // a same-cycle dequeue frees a slot for this pop
  assign rd = ~rst & ~fifo_empty & pop_en &
              (fill < (3'd2 + {2'b0, deq}));
  assign fifo_rd = rd;

  assign cap_eob = inflight_q & fifo_eob;

  always_comb begin
    state_d = state_q;
    stop_d  = 1'b0;
    unique case (osf_ob_dbg_mode_e'(dbg_mode))
      DBG_RUN:   state_d = ST_RUN;
      DBG_HALT:  state_d = ST_HALTED;
      DBG_SSTEP: state_d = ST_STEP;
      DBG_STOP_EOB: begin
        stop_d  = stop_q | cap_eob;
        state_d = stop_d ? ST_HALTED : ST_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    csum = {1'b0, cred_q} +
           {{SSC_W{1'b0}}, single_step_rd};
    if (rd && state_q == ST_STEP)
      csum = csum - 1'b1;
    if (csum > CRED_MAX)
      csum = CRED_MAX;
    cred_d = csum[SSC_W-1:0];
    if (state_q == ST_STEP && state_d != ST_STEP)
      cred_d = '0;
  end

  always_comb begin
    popc_d = popc_q;
    if (state_q != ST_RUN && state_d == ST_RUN)
      popc_d = '0;
    else if (rd && state_q != ST_RUN)
      popc_d = popc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      stop_q     <= 1'b0;
      cred_q     <= '0;
      popc_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stop_q     <= stop_d;
      cred_q     <= cred_d;
      popc_q     <= popc_d;
      inflight_q <= rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_q <= 1'b0;
      amt_q <= '0;
      frm_q <= 1'b0;
    end else begin
      stb_q <= deq;
      amt_q <= deq ? ob_bytes_vld : 4'd0;
      frm_q <= deq & ob_eob;
    end
  end

  assign ob_bytes_cnt_stb = stb_q;
  assign ob_bytes_cnt_amt = amt_q;
  assign ob_frame_cnt_stb = frm_q;

  ob_gate_dbg_stat_t st;

  always_comb begin
    st.state     = state_q;
    st.ss_credit = 4'(cred_q);
    st.occ       = occ;
    st.pop_cnt   = 16'(popc_q);
  end

  assign dbg_stat = st;

endmodule
